// File: rtl/kf_step_ctrl.sv
// Kalman filter iteration sequencer: takes one measurement per step, then walks
// predict -> prior covariance -> gain -> posterior (state and covariance in parallel).
module kf_step_ctrl #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             meas_valid,
    output logic             meas_ready,
    output logic             latch_meas,
    output logic             pred_start,
    input  logic             pred_done,
    output logic             pcov_start,
    input  logic             pcov_done,
    output logic             gain_start,
    input  logic             gain_done,
    output logic             postx_start,
    input  logic             postx_done,
    output logic             postp_start,
    input  logic             postp_done,
    output logic             busy,
    output logic [2:0]       stage,
    output logic             step_done,
    output logic [CNT_W-1:0] iter_cnt,
    output logic             err_timeout,
    input  logic             err_clr
);

    localparam int WD_W = $clog2(TIMEOUT);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PRED = 3'd1,
        S_PCOV = 3'd2,
        S_GAIN = 3'd3,
        S_POST = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [WD_W-1:0]  wd_q, wd_d;
    logic             fx_q, fx_d;
    logic             fp_q, fp_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] iter_q, iter_d;
    logic             pred_start_q, pred_start_d;
    logic             pcov_start_q, pcov_start_d;
    logic             gain_start_q, gain_start_d;
    logic             post_start_q, post_start_d;
    logic             step_done_q, step_done_d;
    logic             handshake;
    logic             stage_exit;
    logic             timeout;

    assign meas_ready = (state_q == S_IDLE) && enable && !err_q;
    assign latch_meas = meas_valid && meas_ready;
    assign handshake  = latch_meas;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            wd_q         <= '0;
            fx_q         <= 1'b0;
            fp_q         <= 1'b0;
            err_q        <= 1'b0;
            iter_q       <= '0;
            pred_start_q <= 1'b0;
            pcov_start_q <= 1'b0;
            gain_start_q <= 1'b0;
            post_start_q <= 1'b0;
            step_done_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            wd_q         <= wd_d;
            fx_q         <= fx_d;
            fp_q         <= fp_d;
            err_q        <= err_d;
            iter_q       <= iter_d;
            pred_start_q <= pred_start_d;
            pcov_start_q <= pcov_start_d;
            gain_start_q <= gain_start_d;
            post_start_q <= post_start_d;
            step_done_q  <= step_done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        stage_exit = 1'b0;
        unique case (state_q)
            S_IDLE: if (handshake) state_d = S_PRED;
            S_PRED: begin
                stage_exit = pred_done;
                if (stage_exit) state_d = S_PCOV;
            end
            S_PCOV: begin
                stage_exit = pcov_done;
                if (stage_exit) state_d = S_GAIN;
            end
            S_GAIN: begin
                stage_exit = gain_done;
                if (stage_exit) state_d = S_POST;
            end
            S_POST: begin
                // Either posterior done may arrive first; a remembered flag stands in for it.
                stage_exit = (fx_q || postx_done) && (fp_q || postp_done);
                if (stage_exit) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        timeout = (state_q != S_IDLE) && (wd_q == WD_LAST) && !stage_exit;
        if (timeout) state_d = S_IDLE;

        if (state_d != state_q || state_q == S_IDLE) wd_d = '0;
        else                                         wd_d = wd_q + 1'b1;

        if (state_q == S_POST && state_d == S_POST) begin
            fx_d = fx_q || postx_done;
            fp_d = fp_q || postp_done;
        end else begin
            fx_d = 1'b0;
            fp_d = 1'b0;
        end
    end

    always_comb begin
        pred_start_d = (state_d == S_PRED) && (state_q != S_PRED);
        pcov_start_d = (state_d == S_PCOV) && (state_q != S_PCOV);
        gain_start_d = (state_d == S_GAIN) && (state_q != S_GAIN);
        post_start_d = (state_d == S_POST) && (state_q != S_POST);
        step_done_d  = (state_q == S_POST) && stage_exit;
        iter_d       = iter_q + CNT_W'(step_done_d);
        // A fresh timeout outranks a simultaneous clear.
        if (timeout)      err_d = 1'b1;
        else if (err_clr) err_d = 1'b0;
        else              err_d = err_q;
    end

    assign pred_start  = pred_start_q;
    assign pcov_start  = pcov_start_q;
    assign gain_start  = gain_start_q;
    assign postx_start = post_start_q;
    assign postp_start = post_start_q;
    assign busy        = (state_q != S_IDLE);
    assign stage       = state_q;
    assign step_done   = step_done_q;
    assign iter_cnt    = iter_q;
    assign err_timeout = err_q;

endmodule
